// File: rtl/rvfi_seq_pkg.sv
// Shared types and constants for the RVFI check sequencer.
package rvfi_seq_pkg;

   localparam int CYC_W = 8;
   localparam logic [CYC_W-1:0] CYC_MAX = '1;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_WARMUP = 3'd1,
      ST_FIRE   = 3'd2,
      ST_DONE   = 3'd3,
      ST_HALTED = 3'd4
   } seq_state_t;

endpackage

// File: rtl/rvfi_retire_count.sv
// Popcount and lowest-set-index encoder over the NRET retire-valid vector.
module rvfi_retire_count
   import rvfi_seq_pkg::*;
#(
   parameter int NRET   = 1,
   parameter int SLOT_W = 1,
   parameter int POP_W  = 1
) (
   input  logic [NRET-1:0]   valid,
   output logic [POP_W-1:0]  pop,
   output logic [SLOT_W-1:0] slot,
   output logic              any
);

   // Walk from the top down so the lowest valid index is the last one written.
   always_comb begin
      pop  = '0;
      slot = '0;
      any  = 1'b0;
      for (int k = NRET - 1; k >= 0; k--) begin
         if (valid[k]) begin
            pop  = pop + POP_W'(1);
            slot = SLOT_W'(k);
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rvfi_check_sequencer.sv
// Sequences one bounded check run: core reset, warm-up, single checker enable pulse.
// Optional retire-order monotonicity check enabled by RISCV_FORMAL_ORDER_CHECK_EN.
module rvfi_check_sequencer
   import rvfi_seq_pkg::*;
#(
   parameter int NRET         = 1,
   parameter int RESET_CYCLES = 5,
   parameter int CHECK_CYCLE  = 20,
   parameter int CNT_W        = 16
) (
   input  logic                                 clk,
   input  logic                                 resetn,
   input  logic [NRET-1:0]                      rvfi_valid,
   input  logic [NRET-1:0]                      rvfi_halt,
   input  logic [64*NRET-1:0]                   rvfi_order,
   output logic                                 core_reset,
   output logic                                 checker_enable,
   output logic [((NRET > 1) ? $clog2(NRET) : 1)-1:0] check_slot,
   output logic                                 check_hit,
   output logic [2:0]                           seq_state,
   output logic [CNT_W-1:0]                     retire_cnt,
   output logic                                 order_err
);

   localparam int SLOT_W = (NRET > 1) ? $clog2(NRET) : 1;
   localparam int POP_W  = $clog2(NRET + 1);
   localparam int SUM_W  = CNT_W + POP_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CYC_W:0]   RST_END = (CYC_W + 1)'(RESET_CYCLES);
   localparam logic [CYC_W:0]   CHK_END = (CYC_W + 1)'(CHECK_CYCLE);

   seq_state_t        state, state_nx;
   logic [CYC_W-1:0]  cycle;
   logic [CYC_W:0]    cyc_inc;
   logic [POP_W-1:0]  pop;
   logic [SLOT_W-1:0] slot;
   logic              any_valid, halt_any, live;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [POP_W-1:0] b);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(a) + SUM_W'(b);
      if (sum > SUM_W'(CNT_MAX)) return CNT_MAX;
      return sum[CNT_W-1:0];
   endfunction

   rvfi_retire_count #(.NRET(NRET), .SLOT_W(SLOT_W), .POP_W(POP_W)) u_count (
      .valid (rvfi_valid),
      .pop   (pop),
      .slot  (slot),
      .any   (any_valid)
   );

   assign cyc_inc   = {1'b0, cycle} + (CYC_W + 1)'(1);
   assign halt_any  = |(rvfi_valid & rvfi_halt);
   assign live      = (state != ST_RESET) && (state != ST_HALTED);
   assign seq_state = state;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_RESET;
      else         state <= state_nx;
   end

   // A halt seen in the last warm-up cycle wins over the move to FIRE.
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_RESET:  if (cyc_inc == RST_END) state_nx = ST_WARMUP;
         ST_WARMUP: begin
            if (halt_any)                  state_nx = ST_HALTED;
            else if (cyc_inc == CHK_END)   state_nx = ST_FIRE;
         end
         ST_FIRE:   state_nx = ST_DONE;
         default:   state_nx = state;
      endcase
   end

   // check_hit/check_slot capture the FIRE-cycle inputs and are visible from the following cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cycle          <= '0;
         core_reset     <= 1'b1;
         checker_enable <= 1'b0;
         check_hit      <= 1'b0;
         check_slot     <= '0;
         retire_cnt     <= '0;
      end else begin
         if (cycle != CYC_MAX) cycle <= cycle + CYC_W'(1);
         core_reset     <= (state_nx == ST_RESET);
         checker_enable <= (state_nx == ST_FIRE);
         if (state == ST_FIRE) begin
            check_hit  <= any_valid;
            check_slot <= slot;
         end
         if (live) retire_cnt <= sat_add(retire_cnt, pop);
      end
   end

`ifdef RISCV_FORMAL_ORDER_CHECK_EN
   logic [63:0] last_order, order_hi, order_exp;
   logic        seen, seen_nx, mismatch;

   always_comb begin
      mismatch  = 1'b0;
      seen_nx   = seen;
      order_hi  = last_order;
      order_exp = last_order + 64'd1;
      for (int k = 0; k < NRET; k++) begin
         if (rvfi_valid[k]) begin
            if (seen_nx && (rvfi_order[64*k +: 64] != order_exp)) mismatch = 1'b1;
            seen_nx   = 1'b1;
            order_hi  = rvfi_order[64*k +: 64];
            order_exp = rvfi_order[64*k +: 64] + 64'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_order <= '0;
         seen       <= 1'b0;
         order_err  <= 1'b0;
      end else if (state != ST_RESET) begin
         last_order <= order_hi;
         seen       <= seen_nx;
         if (mismatch) order_err <= 1'b1;
      end
   end

`ifdef FORMAL
   always_comb assert (!order_err);
`endif
`else
   logic unused_order;
   assign unused_order = ^rvfi_order;
   assign order_err    = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Randomized self-checking bench: three sequencer configurations against a cycle-index model.
module tb_rvfi_check_sequencer;

   localparam int RC = 5;
   localparam int CC = 20;

   logic         clk = 1'b0;
   logic         resetn;
   logic [1:0]   valid, halt;
   logic [127:0] order;

   logic [2:0]  cr, en, hit, oe;
   logic [2:0]  st_a, st_b, st_c;
   logic [0:0]  slot_a, slot_b, slot_c;
   logic [15:0] cnt_a, cnt_c;
   logic [3:0]  cnt_b;

   int tests = 0;
   int fails = 0;
   bit model_on = 1'b0;
   logic [63:0] ord_nxt;

   always #5 clk = ~clk;

   rvfi_check_sequencer #(.NRET(2), .RESET_CYCLES(RC), .CHECK_CYCLE(CC), .CNT_W(16)) dut_a (
      .clk(clk), .resetn(resetn), .rvfi_valid(valid), .rvfi_halt(halt), .rvfi_order(order),
      .core_reset(cr[0]), .checker_enable(en[0]), .check_slot(slot_a), .check_hit(hit[0]),
      .seq_state(st_a), .retire_cnt(cnt_a), .order_err(oe[0]));

   rvfi_check_sequencer #(.NRET(2), .RESET_CYCLES(RC), .CHECK_CYCLE(CC), .CNT_W(4)) dut_b (
      .clk(clk), .resetn(resetn), .rvfi_valid(valid), .rvfi_halt(halt), .rvfi_order(order),
      .core_reset(cr[1]), .checker_enable(en[1]), .check_slot(slot_b), .check_hit(hit[1]),
      .seq_state(st_b), .retire_cnt(cnt_b), .order_err(oe[1]));

   rvfi_check_sequencer #(.NRET(1), .RESET_CYCLES(RC), .CHECK_CYCLE(CC), .CNT_W(16)) dut_c (
      .clk(clk), .resetn(resetn), .rvfi_valid(valid[0]), .rvfi_halt(halt[0]),
      .rvfi_order(order[63:0]),
      .core_reset(cr[2]), .checker_enable(en[2]), .check_slot(slot_c), .check_hit(hit[2]),
      .seq_state(st_c), .retire_cnt(cnt_c), .order_err(oe[2]));

   // Model: everything follows from the cycle index since resetn rose.
   int         n;
   int         m_cnt[3];
   bit         m_halt[3], m_hit[3], m_oerr[3];
   int         m_slot[3];
   int         cmax[3]  = '{65535, 15, 65535};
   logic [1:0] cmask[3] = '{2'b11, 2'b11, 2'b01};
   string      nm[3]    = '{"a", "b", "c"};
`ifdef RISCV_FORMAL_ORDER_CHECK_EN
   bit          m_seen[3];
   logic [63:0] m_last[3];
`endif

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      n = 0;
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0; m_halt[i] = 0; m_hit[i] = 0; m_slot[i] = 0; m_oerr[i] = 0;
`ifdef RISCV_FORMAL_ORDER_CHECK_EN
         m_seen[i] = 0; m_last[i] = '0;
`endif
      end
   endtask

   task automatic compare_all();
      int a_st[3], a_slot[3], a_cnt[3];
      a_st[0] = int'(st_a);   a_st[1] = int'(st_b);   a_st[2] = int'(st_c);
      a_slot[0] = int'(slot_a); a_slot[1] = int'(slot_b); a_slot[2] = int'(slot_c);
      a_cnt[0] = int'(cnt_a); a_cnt[1] = int'(cnt_b); a_cnt[2] = int'(cnt_c);
      for (int i = 0; i < 3; i++) begin
         int es;
         es = (n < RC) ? 0 : m_halt[i] ? 4 : (n < CC) ? 1 : (n == CC) ? 2 : 3;
         check($sformatf("c%0d.%s.state", n, nm[i]), a_st[i], es);
         check($sformatf("c%0d.%s.core_reset", n, nm[i]), cr[i], (n < RC) ? 1 : 0);
         check($sformatf("c%0d.%s.enable", n, nm[i]), en[i], (es == 2) ? 1 : 0);
         check($sformatf("c%0d.%s.hit", n, nm[i]), hit[i], m_hit[i]);
         check($sformatf("c%0d.%s.slot", n, nm[i]), a_slot[i], m_slot[i]);
         check($sformatf("c%0d.%s.cnt", n, nm[i]), a_cnt[i], m_cnt[i]);
         check($sformatf("c%0d.%s.order_err", n, nm[i]), oe[i], m_oerr[i]);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         logic [1:0] v, h;
         int pc;
         v  = valid & cmask[i];
         h  = halt & cmask[i];
         pc = int'(v[0]) + int'(v[1]);
         if (n >= RC && !m_halt[i]) m_cnt[i] = (m_cnt[i] + pc > cmax[i]) ? cmax[i] : m_cnt[i] + pc;
         if (n == CC && !m_halt[i]) begin
            m_hit[i]  = (v != 2'b00);
            m_slot[i] = v[0] ? 0 : (v[1] ? 1 : 0);
         end
`ifdef RISCV_FORMAL_ORDER_CHECK_EN
         if (n >= RC) begin
            for (int k = 0; k < 2; k++) begin
               if (v[k]) begin
                  logic [63:0] o;
                  o = order[64*k +: 64];
                  if (m_seen[i] && o != m_last[i] + 64'd1) m_oerr[i] = 1;
                  m_seen[i] = 1;
                  m_last[i] = o;
               end
            end
         end
`endif
         if (n >= RC && n < CC && !m_halt[i] && (v & h) != 2'b00) m_halt[i] = 1;
      end
      n++;
   endtask

   always @(negedge clk) begin
      if (model_on) begin
         if (!resetn) begin
            model_reset();
            compare_all();
         end else begin
            compare_all();
            model_step();
         end
      end
   end

   task automatic drive(input logic [1:0] v, input logic [1:0] h);
      logic [63:0] o[2];
      for (int k = 0; k < 2; k++) begin
         if (v[k]) begin
            ord_nxt = ord_nxt + (($urandom_range(0, 29) == 0) ? 64'd2 : 64'd1);
            o[k] = ord_nxt;
         end else begin
            o[k] = {$urandom, $urandom};
         end
      end
      valid = v;
      halt  = h;
      order = {o[1], o[0]};
   endtask

   // Entered at posedge+1; leaves resetn high at posedge+1 at the start of cycle 0.
   task automatic apply_reset();
      #2;
      resetn   = 1'b0;
      model_on = 1'b1;
      #1;
      check("async.core_reset", cr, 3'b111);
      check("async.enable", en, 3'b000);
      check("async.state_a", st_a, 0);
      check("async.cnt_a", cnt_a, 0);
      check("async.hit", hit, 3'b000);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      valid  = '0;
      halt   = '0;
      resetn = 1'b1;
   endtask

   // mode: 0 all valid, 1 valid=10 at check, 2 none at check, 3 halt at 12, 5 halt at check, else random
   task automatic run(input int len, input int mode);
      for (int k = 0; k < len; k++) begin
         logic [1:0] v, h;
         v = 2'($urandom_range(0, 3));
         h = 2'b00;
         case (mode)
            0: v = 2'b11;
            1: if (k == CC) v = 2'b10;
            2: if (k == CC) v = 2'b00;
            3: begin v = 2'b11; if (k == 12) h = 2'b01; end
            5: if (k == CC) begin v = 2'b11; h = 2'b11; end
            default: if ($urandom_range(0, 24) == 0) h = 2'($urandom_range(1, 3));
         endcase
         drive(v, h);
         @(negedge clk);
         if (mode == 0 && k == 4)  check("lit.reset_hi", cr[0], 1);
         if (mode == 0 && k == 5)  check("lit.reset_lo", cr[0], 0);
         if (mode == 0 && k == 19) check("lit.en_before", en[0], 0);
         if (mode == 0 && k == 20) begin
            check("lit.en_fire", en[0], 1);
            check("lit.cnt_a", cnt_a, 30);
            check("lit.cnt_b_sat", cnt_b, 15);
            check("lit.cnt_c", cnt_c, 15);
         end
         if (mode == 0 && k == 21) begin
            check("lit.en_after", en[0], 0);
            check("lit.hit", hit[0], 1);
            check("lit.slot0", slot_a, 0);
         end
         if (mode == 1 && k == 21) begin
            check("lit.slot1", slot_a, 1);
            check("lit.hit_a", hit[0], 1);
            check("lit.hit_c_none", hit[2], 0);
         end
         if (mode == 2 && k == 20) check("lit.en_no_valid", en[0], 1);
         if (mode == 2 && k == 21) check("lit.hit_none", hit[0], 0);
         if (mode == 3 && k == 13) check("lit.halted", st_a, 4);
         if (mode == 3 && k == 20) check("lit.halt_no_en", en[0], 0);
         if (mode == 3 && k == 25) begin
            check("lit.halt_cnt_a", cnt_a, 16);
            check("lit.halt_cnt_c", cnt_c, 8);
         end
         if (mode == 5 && k == 21) begin
            check("lit.fire_halt_done", st_a, 3);
            check("lit.fire_halt_hit", hit[0], 1);
         end
         if (k == len - 1) check("lit.order_err_off", oe[1], 0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      resetn  = 1'b1;
      valid   = '0;
      halt    = '0;
      order   = '0;
      ord_nxt = '0;
      @(posedge clk);
      #1;
      apply_reset();
      run(30, 0);
      apply_reset();
      run(28, 1);
      apply_reset();
      run(28, 2);
      apply_reset();
      run(30, 3);
      apply_reset();
      run(26, 5);
      apply_reset();
      run(10, 4);
      apply_reset();
      run(30, 4);
      for (int r = 0; r < 8; r++) begin
         apply_reset();
         run(40, 4);
      end
      apply_reset();
      run(300, 4);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
